// File: rtl/sketch_pkg.sv
// sketch_pkg: shared constants, FSM state type and cell-address helper for the sketch pixel generator
package sketch_pkg;
   localparam int COLS = 80;
   localparam int ROWS = 60;
   localparam int CELL_LOG2 = 3;
   localparam int ADDR_W = 13;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
   localparam logic [6:0] HOME_COL = 7'd40;
   localparam logic [5:0] HOME_ROW = 6'd30;
   localparam logic [11:0] BG_COLOR = 12'hFFF;
   localparam logic [11:0] INK_COLOR = 12'h000;
   localparam logic [11:0] CURSOR_COLOR = 12'hF00;
   typedef enum logic [1:0] {CLEAR, INK, IDLE} state_t;
   // row*80 built as row*64 + row*16 so no multiplier is needed
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] c, input logic [6:0] r);
      logic [ADDR_W-1:0] rr;
      rr = {6'd0, r};
      return (rr << 6) + (rr << 4) + {6'd0, c};
   endfunction
endpackage

// File: rtl/sketch_bitmap_ram.sv
// sketch_bitmap_ram: 4800x1 simple dual-port trail bitmap with registered read
// Ports: clk; we/waddr/wdata write port; raddr read address, rdata registered read data
module sketch_bitmap_ram
   import sketch_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic              wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic              rdata
);
   logic mem [0:COLS*ROWS-1];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/sketch_pixel_gen.sv
// sketch_pixel_gen: Etch-A-Sketch cursor/trail state and registered 12-bit RGB pixel output
// Ports: clk_100MHz, reset (async, active-high); video_on/p_tick/x/y from the VGA timing block;
//        btn_up/down/left/right direction levels; btn_clear (rising edge wipes the bitmap);
//        rgb {R,G,B} pixel, 2 clocks behind x/y; busy high while a clear sequence runs
module sketch_pixel_gen
   import sketch_pkg::*;
#(
   parameter int MOVE_DIV = 4
)(
   input  logic        clk_100MHz,
   input  logic        reset,
   input  logic        video_on,
   input  logic        p_tick,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_clear,
   output logic [11:0] rgb,
   output logic        busy
);
   state_t state, nstate;
   logic [ADDR_W-1:0] clr_addr, waddr, raddr;
   logic [6:0] cur_c, nxt_c;
   logic [5:0] cur_r, nxt_r;
   logic [7:0] cnt;
   logic clr_q, from_clear, we, wdata, tick, clr_edge, any_dir, step, moved;
   logic rbit, vid_q, cur_q, unused_ok;
   assign unused_ok = ^{x[CELL_LOG2-1:0], y[CELL_LOG2-1:0]};
   assign tick = p_tick && x == 10'd0 && y == 10'd480;
   assign clr_edge = btn_clear && !clr_q;
   assign any_dir = btn_up | btn_down | btn_left | btn_right;
   assign step = state == IDLE && tick && !clr_edge && any_dir && cnt == 8'd0;
   // opposing buttons cancel on their axis; clamped steps leave the coordinate unchanged
   assign nxt_c = (btn_right && !btn_left && cur_c != 7'(COLS - 1)) ? cur_c + 7'd1 :
                  (btn_left && !btn_right && cur_c != 7'd0) ? cur_c - 7'd1 : cur_c;
   assign nxt_r = (btn_down && !btn_up && cur_r != 6'(ROWS - 1)) ? cur_r + 6'd1 :
                  (btn_up && !btn_down && cur_r != 6'd0) ? cur_r - 6'd1 : cur_r;
   // a fully blocked step does not visit INK, so nothing is written
   assign moved = step && (nxt_c != cur_c || nxt_r != cur_r);
   always_ff @(posedge clk_100MHz or posedge reset)
      if (reset) state <= CLEAR;
      else state <= nstate;
   always_comb begin
      nstate = state == CLEAR ? (clr_addr == LAST_ADDR ? INK : CLEAR) :
               state == INK   ? IDLE :
               clr_edge       ? CLEAR :
               moved          ? INK : IDLE;
   end
   always_comb begin
      we = state != IDLE;
      wdata = state == INK;
      waddr = state == CLEAR ? clr_addr : cell_addr(cur_c, {1'b0, cur_r});
      busy = state == CLEAR || (state == INK && from_clear);
   end
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         clr_addr <= '0;
         cur_c <= HOME_COL;
         cur_r <= HOME_ROW;
         cnt <= 8'd0;
         clr_q <= 1'b0;
         from_clear <= 1'b1;
      end else begin
         clr_q <= btn_clear;
         if (state == CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            from_clear <= 1'b1;
         end
         if (state == IDLE) begin
            from_clear <= 1'b0;
            if (clr_edge) begin
               clr_addr <= '0;
               cur_c <= HOME_COL;
               cur_r <= HOME_ROW;
            end else if (tick) begin
               cnt <= (!any_dir || cnt == 8'(MOVE_DIV - 1)) ? 8'd0 : cnt + 8'd1;
               if (moved) begin
                  cur_c <= nxt_c;
                  cur_r <= nxt_r;
               end
            end
         end
      end
   end
   assign raddr = cell_addr(x[9:CELL_LOG2], y[9:CELL_LOG2]);
   sketch_bitmap_ram u_ram (
      .clk   (clk_100MHz),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rbit)
   );
   // stage 1 lines up video_on and the cursor compare with the RAM read; stage 2 picks the colour
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         vid_q <= 1'b0;
         cur_q <= 1'b0;
         rgb <= 12'h000;
      end else begin
         vid_q <= video_on;
         cur_q <= x[9:CELL_LOG2] == cur_c && y[9:CELL_LOG2] == {1'b0, cur_r};
         rgb <= !vid_q ? 12'h000 : cur_q ? CURSOR_COLOR : rbit ? INK_COLOR : BG_COLOR;
      end
   end
endmodule

// File: tb/tb_sketch_pixel_gen.sv
// tb_sketch_pixel_gen: directed scoreboard bench for sketch_pixel_gen
module tb_sketch_pixel_gen;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic video_on = 1'b0, p_tick = 1'b0;
   logic [9:0] x = '0, y = '0;
   logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_clear = 1'b0;
   logic [11:0] rgb;
   logic busy;
   sketch_pixel_gen #(.MOVE_DIV(4)) dut (
      .clk_100MHz (clk),
      .reset      (reset),
      .video_on   (video_on),
      .p_tick     (p_tick),
      .x          (x),
      .y          (y),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_clear  (btn_clear),
      .rgb        (rgb),
      .busy       (busy)
   );
   always #5 clk = ~clk;
   typedef struct {
      int          cyc;
      bit          kind;
      logic [11:0] exp;
      string       name;
   } exp_t;
   exp_t q[$];
   exp_t m_e;
   logic [11:0] m_act;
   int cyc = 0, checks = 0, errors = 0;
   always @(posedge clk) cyc <= cyc + 1;
   // kind 0 compares rgb, kind 1 compares busy, at the clock the entry is due
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         m_e = q.pop_front();
         m_act = m_e.kind ? {11'd0, busy} : rgb;
         checks++;
         if (m_e.cyc != cyc) begin
            errors++;
            $display("FAIL %s: missed at cycle %0d (due %0d)", m_e.name, cyc, m_e.cyc);
         end else if (m_act !== m_e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", m_e.name, m_act, m_e.exp, cyc);
         end
      end
   end
   task automatic expect_at(input int lat, input bit kind, input logic [11:0] exp, input string name);
      q.push_back('{cyc + lat, kind, exp, name});
   endtask
   task automatic pix(input int px, input int py, input logic [11:0] exp, input string name);
      @(negedge clk);
      x = 10'(px);
      y = 10'(py);
      video_on = 1'b1;
      expect_at(2, 1'b0, exp, name);
      repeat (2) @(negedge clk);
   endtask
   task automatic frame_tick();
      @(negedge clk);
      video_on = 1'b0;
      x = 10'd0;
      y = 10'd480;
      p_tick = 1'b1;
      @(negedge clk);
      p_tick = 1'b0;
      y = 10'd0;
      repeat (2) @(negedge clk);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      expect_at(1, 1'b0, 12'h000, "reset_rgb");
      expect_at(1, 1'b1, 12'h001, "reset_busy");
      repeat (7) @(negedge clk);
      reset = 1'b0;
      expect_at(1, 1'b1, 12'h001, "busy_start");
      expect_at(4800, 1'b1, 12'h001, "busy_ink");
      expect_at(4801, 1'b1, 12'h000, "busy_done");
      repeat (4805) @(negedge clk);
      pix(324, 244, 12'hF00, "home_cursor");
      pix(0, 0, 12'hFFF, "home_bg");
      btn_right = 1'b1;
      repeat (8) frame_tick();
      btn_right = 1'b0;
      pix(328, 244, 12'h000, "trail_41");
      pix(320, 244, 12'h000, "trail_40");
      pix(336, 244, 12'hF00, "cursor_42");
      pix(344, 244, 12'hFFF, "bg_43");
      btn_left = 1'b1;
      repeat (200) frame_tick();
      btn_left = 1'b0;
      pix(0, 244, 12'hF00, "clamp_col0");
      pix(8, 244, 12'h000, "trail_1");
      pix(330, 244, 12'h000, "trail_41b");
      btn_up = 1'b1;
      btn_down = 1'b1;
      btn_right = 1'b1;
      frame_tick();
      btn_up = 1'b0;
      btn_down = 1'b0;
      btn_right = 1'b0;
      pix(8, 244, 12'hF00, "diag_col1");
      pix(0, 244, 12'h000, "diag_old");
      pix(8, 236, 12'hFFF, "diag_row29");
      pix(8, 252, 12'hFFF, "diag_row31");
      @(negedge clk);
      x = 10'd7;
      y = 10'd244;
      video_on = 1'b1;
      repeat (3) @(negedge clk);
      x = 10'd8;
      expect_at(1, 1'b0, 12'h000, "edge_hold");
      expect_at(2, 1'b0, 12'hF00, "edge_update");
      repeat (3) @(negedge clk);
      x = 10'd700;
      video_on = 1'b0;
      expect_at(2, 1'b0, 12'h000, "video_off");
      repeat (3) @(negedge clk);
      frame_tick();
      @(negedge clk);
      btn_down = 1'b1;
      expect_at(1, 1'b1, 12'h000, "busy_pre");
      @(negedge clk);
      btn_clear = 1'b1;
      video_on = 1'b0;
      x = 10'd0;
      y = 10'd480;
      p_tick = 1'b1;
      expect_at(1, 1'b1, 12'h001, "busy_rise");
      expect_at(4801, 1'b1, 12'h001, "busy_hold");
      expect_at(4802, 1'b1, 12'h000, "busy_end");
      @(negedge clk);
      p_tick = 1'b0;
      y = 10'd0;
      btn_down = 1'b0;
      btn_clear = 1'b0;
      repeat (4805) @(negedge clk);
      pix(324, 244, 12'hF00, "clr_cursor");
      pix(8, 252, 12'hFFF, "clr_dropped");
      pix(8, 244, 12'hFFF, "clr_col1");
      pix(0, 244, 12'hFFF, "clr_col0");
      pix(330, 244, 12'hFFF, "clr_col41");
      for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d checks pending, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
